// File: rtl/mem_access_stage_pkg.sv
// rtl/mem_access_stage_pkg.sv - shared CPU package: memory-stage state encoding and defaults
package mem_access_stage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } mem_state_e;

  localparam int unsigned TIMEOUT_DEFAULT = 255;

  // Byte loads return the lane picked by the address LSB, zero-extended.
  function automatic logic [15:0] lane_select(input logic [15:0] data, input logic hi_lane);
    return hi_lane ? {8'h00, data[15:8]} : {8'h00, data[7:0]};
  endfunction

endpackage

// File: rtl/mem_access_stage_ctrl_decode.sv
// rtl/mem_access_stage_ctrl_decode.sv - extracts memory-access flags from the control word
module ctrl_decode (
  input  logic [32:0] ctrl_word,
  output logic        mem_read_b,
  output logic        mem_read_w,
  output logic        mem_write_b,
  output logic        mem_write_w
);

  localparam int MEM_READ_B_BIT  = 20;
  localparam int MEM_READ_W_BIT  = 21;
  localparam int MEM_WRITE_B_BIT = 22;
  localparam int MEM_WRITE_W_BIT = 23;

  assign mem_read_b  = ctrl_word[MEM_READ_B_BIT];
  assign mem_read_w  = ctrl_word[MEM_READ_W_BIT];
  assign mem_write_b = ctrl_word[MEM_WRITE_B_BIT];
  assign mem_write_w = ctrl_word[MEM_WRITE_W_BIT];

  // Remaining fields belong to other stages.
  logic unused_bits;
  assign unused_bits = ^{ctrl_word[32:24], ctrl_word[19:0]};

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - pipeline memory stage: bus load/store with timeout and fault pulses
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic [15:0] pc_in,
  input  logic [15:0] imm_in,
  input  logic [32:0] control_signals_in,
  input  logic [15:0] addr_in,
  input  logic [15:0] wdata_in,
  output logic        bus_req,
  output logic        bus_we,
  output logic        bus_byte,
  output logic [15:0] bus_addr,
  output logic [15:0] bus_wdata,
  input  logic [15:0] bus_rdata,
  input  logic        bus_ack,
  output logic        stall,
  output logic        valid_out,
  output logic [15:0] memData_out,
  output logic [32:0] control_signals_out,
  output logic [15:0] pc_out,
  output logic [15:0] imm_out,
  output logic        bus_err
);

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

  mem_state_e  state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        valid_out_q, valid_out_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic        bus_byte_q, bus_byte_d;
  logic        bus_err_q, bus_err_d;
  logic [15:0] bus_addr_q, bus_addr_d;
  logic [15:0] bus_wdata_q, bus_wdata_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] mem_data_q, mem_data_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] imm_q, imm_d;
  logic [32:0] ctrl_q, ctrl_d;

  logic rd_b, rd_w, wr_b, wr_w;
  logic is_read, is_write, any_mem, byte_sz;

  ctrl_decode u_ctrl_decode (
    .ctrl_word   (control_signals_in),
    .mem_read_b  (rd_b),
    .mem_read_w  (rd_w),
    .mem_write_b (wr_b),
    .mem_write_w (wr_w)
  );

  assign is_read  = rd_b | rd_w;
  assign is_write = wr_b | wr_w;
  assign any_mem  = is_read | is_write;
  // A write wins over a read; any W flag of the chosen direction makes it a word access.
  assign byte_sz  = is_write ? (wr_b & ~wr_w) : (rd_b & ~rd_w);

  assign stall = (state_q == ST_ACCESS) || ((state_q == ST_IDLE) && valid_in && any_mem);

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    valid_out_d = 1'b0;
    bus_err_d   = 1'b0;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_byte_d  = bus_byte_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    addr_d      = addr_q;
    mem_data_d  = mem_data_q;
    pc_d        = pc_q;
    imm_d       = imm_q;
    ctrl_d      = ctrl_q;

    case (state_q)
      ST_IDLE: begin
        if (valid_in) begin
          pc_d   = pc_in;
          imm_d  = imm_in;
          ctrl_d = control_signals_in;
          addr_d = addr_in;
          if (!any_mem) begin
            valid_out_d = 1'b1;
            mem_data_d  = addr_in;
          end else begin
            state_d     = ST_ACCESS;
            wait_cnt_d  = 8'd0;
            bus_req_d   = 1'b1;
            bus_we_d    = is_write;
            bus_byte_d  = byte_sz;
            bus_addr_d  = byte_sz ? addr_in : {addr_in[15:1], 1'b0};
            bus_wdata_d = byte_sz ? {2{wdata_in[7:0]}} : wdata_in;
            bus_err_d   = (is_read && is_write) || (!byte_sz && addr_in[0]);
          end
        end
      end
      ST_ACCESS: begin
        if (bus_ack) begin
          state_d     = ST_DONE;
          bus_req_d   = 1'b0;
          valid_out_d = 1'b1;
          if (bus_we_q)
            mem_data_d = addr_q;
          else if (bus_byte_q)
            mem_data_d = lane_select(bus_rdata, addr_q[0]);
          else
            mem_data_d = bus_rdata;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
          if (wait_cnt_q == WAIT_LAST) begin
            state_d     = ST_DONE;
            bus_req_d   = 1'b0;
            valid_out_d = 1'b1;
            mem_data_d  = 16'h0000;
            bus_err_d   = 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      wait_cnt_q  <= 8'd0;
      valid_out_q <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_byte_q  <= 1'b0;
      bus_err_q   <= 1'b0;
      bus_addr_q  <= 16'h0000;
      bus_wdata_q <= 16'h0000;
      addr_q      <= 16'h0000;
      mem_data_q  <= 16'h0000;
      pc_q        <= 16'h0000;
      imm_q       <= 16'h0000;
      ctrl_q      <= 33'h0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      valid_out_q <= valid_out_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_byte_q  <= bus_byte_d;
      bus_err_q   <= bus_err_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      addr_q      <= addr_d;
      mem_data_q  <= mem_data_d;
      pc_q        <= pc_d;
      imm_q       <= imm_d;
      ctrl_q      <= ctrl_d;
    end
  end

  assign bus_req             = bus_req_q;
  assign bus_we              = bus_we_q;
  assign bus_byte            = bus_byte_q;
  assign bus_addr            = bus_addr_q;
  assign bus_wdata           = bus_wdata_q;
  assign bus_err             = bus_err_q;
  assign valid_out           = valid_out_q;
  assign memData_out         = mem_data_q;
  assign control_signals_out = ctrl_q;
  assign pc_out              = pc_q;
  assign imm_out             = imm_q;

endmodule
